// File: rtl/reg_file_cc_if.sv
// Control/datapath bundle between the SLC-3 controller (master) and the register file/condition-code stage (slave).
interface reg_file_cc_if;
  localparam int unsigned DataW = 16;
  localparam int unsigned CcW   = 3;

  logic [DataW-1:0] IR;
  logic [DataW-1:0] Bus;
  logic             LD_REG;
  logic             LD_CC;
  logic             LD_BEN;
  logic             DRMUX;
  logic             SR1MUX;
  logic [DataW-1:0] SR1_OUT;
  logic [DataW-1:0] ALU_B;
  logic [CcW-1:0]   NZP;
  logic             BEN;

  modport master (
    output IR, Bus, LD_REG, LD_CC, LD_BEN, DRMUX, SR1MUX,
    input  SR1_OUT, ALU_B, NZP, BEN
  );

  modport slave (
    input  IR, Bus, LD_REG, LD_CC, LD_BEN, DRMUX, SR1MUX,
    output SR1_OUT, ALU_B, NZP, BEN
  );
endinterface

// File: rtl/reg_file_cc.sv
// SLC-3 register file (R0-R7) with combinational SR1/SR2 read ports, imm5 sign extension,
// and the NZP condition codes plus registered branch-enable flag.
module reg_file_cc (
  input logic         Clk,
  input logic         Reset,
  reg_file_cc_if.slave bus_if
);
  localparam int unsigned DataW   = 16;
  localparam int unsigned NumRegs = 8;
  localparam int unsigned RegAw   = 3;
  localparam int unsigned CcW     = 3;
  localparam int unsigned ImmW    = 5;

  logic [NumRegs-1:0][DataW-1:0] regs_q, regs_d;
  logic [CcW-1:0]                nzp_q, nzp_d;
  logic                          ben_q, ben_d;

  logic [RegAw-1:0] dr_sel;
  logic [RegAw-1:0] sr1_sel;
  logic [RegAw-1:0] sr2_sel;
  logic [DataW-1:0] imm_sext;
  logic             unused_ir_opcode;

  // Register selects decoded from IR fields.
  always_comb begin
    dr_sel   = bus_if.DRMUX  ? RegAw'(NumRegs - 1) : bus_if.IR[11:9];
    sr1_sel  = bus_if.SR1MUX ? bus_if.IR[8:6]      : bus_if.IR[11:9];
    sr2_sel  = bus_if.IR[2:0];
    imm_sext = {{(DataW - ImmW){bus_if.IR[ImmW-1]}}, bus_if.IR[ImmW-1:0]};
  end

  assign unused_ir_opcode = ^bus_if.IR[15:12];

  // Next-state: level-sampled loads; BEN always sees the NZP held before the edge.
  always_comb begin
    regs_d = regs_q;
    nzp_d  = nzp_q;
    ben_d  = ben_q;
    if (bus_if.LD_REG) begin
      regs_d[dr_sel] = bus_if.Bus;
    end
    if (bus_if.LD_CC) begin
      if (bus_if.Bus[DataW-1]) begin
        nzp_d = 3'b100;
      end else if (bus_if.Bus == '0) begin
        nzp_d = 3'b010;
      end else begin
        nzp_d = 3'b001;
      end
    end
    if (bus_if.LD_BEN) begin
      ben_d = |(bus_if.IR[11:9] & nzp_q);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      regs_q <= '0;
      nzp_q  <= '0;
      ben_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      nzp_q  <= nzp_d;
      ben_q  <= ben_d;
    end
  end

  // Read ports carry no write-through bypass: a same-cycle write shows up after the edge.
  assign bus_if.SR1_OUT = regs_q[sr1_sel];
  assign bus_if.ALU_B   = bus_if.IR[5] ? imm_sext : regs_q[sr2_sel];
  assign bus_if.NZP     = nzp_q;
  assign bus_if.BEN     = ben_q;
endmodule

// File: tb/tb_reg_file_cc.sv
// Scoreboard bench for reg_file_cc: a driver issues directed and random cycles against a
// behavioural model and queues expected outputs; a monitor compares them before each rising edge.
module tb_reg_file_cc;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  reg_file_cc_if rf_if();

  reg_file_cc dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .bus_if (rf_if)
  );

  typedef struct packed {
    logic [15:0] sr1;
    logic [15:0] alu_b;
    logic [2:0]  nzp;
    logic        ben;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_regs [8];
  logic [2:0]  m_nzp;
  logic        m_ben;
  int          errors = 0;
  int          checks = 0;
  bit          drv_done = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] sext5(input logic [4:0] v);
    int x;
    x = int'(v);
    if (x >= 16) x = x - 32;
    return 16'(x);
  endfunction

  function automatic logic [15:0] ir_of(input int dr, input int sr1, input bit immf, input int low5);
    return {4'b0001, 3'(dr), 3'(sr1), immf, 5'(low5)};
  endfunction

  // One clock cycle of stimulus; expected outputs reflect state before this cycle's edge.
  task automatic step(input logic [15:0] ir, input logic [15:0] bus, input bit ld_reg,
                      input bit ld_cc, input bit ld_ben, input bit drmux, input bit sr1mux,
                      input bit rst);
    exp_t e;
    int   sr1i;
    int   dri;
    @(negedge Clk);
    rf_if.IR     = ir;
    rf_if.Bus    = bus;
    rf_if.LD_REG = ld_reg;
    rf_if.LD_CC  = ld_cc;
    rf_if.LD_BEN = ld_ben;
    rf_if.DRMUX  = drmux;
    rf_if.SR1MUX = sr1mux;
    Reset        = rst;
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
      m_nzp = 3'b000;
      m_ben = 1'b0;
    end
    sr1i    = sr1mux ? int'(ir[8:6]) : int'(ir[11:9]);
    e.sr1   = m_regs[sr1i];
    e.alu_b = ir[5] ? sext5(ir[4:0]) : m_regs[int'(ir[2:0])];
    e.nzp   = m_nzp;
    e.ben   = m_ben;
    #1 exp_q.push_back(e);
    if (!rst) begin
      if (ld_ben) m_ben = (ir[11] && m_nzp[2]) || (ir[10] && m_nzp[1]) || (ir[9] && m_nzp[0]);
      if (ld_cc) begin
        if ($signed(bus) < 0) m_nzp = 3'b100;
        else if (bus == 16'h0000) m_nzp = 3'b010;
        else m_nzp = 3'b001;
      end
      if (ld_reg) begin
        dri = drmux ? 7 : int'(ir[11:9]);
        m_regs[dri] = bus;
      end
    end
  endtask

  // Monitor: compares the oldest expectation shortly after the driver has applied inputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sr1_out", rf_if.SR1_OUT, e.sr1);
        check("alu_b", rf_if.ALU_B, e.alu_b);
        check("nzp", 16'(rf_if.NZP), 16'(e.nzp));
        check("ben", 16'(rf_if.BEN), 16'(e.ben));
      end
    end
  end

  initial begin
    logic [15:0] rbus;
    int          sel;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_nzp = 3'b000;
    m_ben = 1'b0;
    rf_if.IR = '0; rf_if.Bus = '0; rf_if.LD_REG = 0; rf_if.LD_CC = 0;
    rf_if.LD_BEN = 0; rf_if.DRMUX = 0; rf_if.SR1MUX = 0;

    // Reset held, then release and sweep all registers.
    step(ir_of(0, 0, 0, 0), 16'h0, 0, 0, 0, 0, 0, 1);
    for (int r = 0; r < 8; r++) step(ir_of(r, 7 - r, 0, r), 16'h0, 0, 0, 0, 0, r % 2, 0);

    // Write R3, then read it through both ports and check neighbours stay zero.
    step(ir_of(3, 0, 0, 0), 16'h1234, 1, 0, 0, 0, 0, 0);
    step(ir_of(0, 3, 0, 3), 16'h0, 0, 0, 0, 0, 1, 0);
    step(ir_of(2, 4, 0, 2), 16'h0, 0, 0, 0, 0, 1, 0);

    // imm5 sign extension, independent of register contents.
    step(ir_of(0, 3, 1, 5'b10001), 16'h0, 0, 0, 0, 0, 1, 0);
    step(ir_of(0, 3, 1, 5'b00111), 16'h0, 0, 0, 0, 0, 1, 0);
    step(ir_of(0, 3, 1, 5'b10000), 16'h0, 0, 0, 0, 0, 1, 0);
    step(ir_of(0, 3, 1, 5'b01111), 16'h0, 0, 0, 0, 0, 1, 0);

    // Condition codes N, Z, P in succession.
    step(ir_of(0, 0, 0, 0), 16'h8000, 0, 1, 0, 0, 0, 0);
    step(ir_of(0, 0, 0, 0), 16'h0000, 0, 1, 0, 0, 0, 0);
    step(ir_of(0, 0, 0, 0), 16'h0001, 0, 1, 0, 0, 0, 0);
    step(ir_of(0, 0, 0, 0), 16'h0000, 0, 1, 0, 0, 0, 0);

    // BEN from old NZP, including LD_CC and LD_BEN in the same cycle.
    step(ir_of(2, 0, 0, 0), 16'h0, 0, 0, 1, 0, 0, 0);
    step(ir_of(2, 0, 0, 0), 16'h0005, 0, 1, 1, 0, 0, 0);
    step(ir_of(2, 0, 0, 0), 16'h0, 0, 0, 1, 0, 0, 0);
    step(ir_of(2, 0, 0, 0), 16'h0, 0, 0, 0, 0, 0, 0);

    // DRMUX forces R7; same-cycle read shows the old value, then async reset mid-cycle.
    step(ir_of(2, 7, 0, 2), 16'hBEEF, 1, 0, 0, 1, 1, 0);
    step(ir_of(7, 2, 0, 2), 16'h0, 0, 0, 0, 0, 0, 0);
    step(ir_of(7, 2, 0, 7), 16'h0, 1, 1, 1, 0, 0, 1);
    step(ir_of(7, 2, 0, 7), 16'h5555, 1, 0, 0, 0, 0, 0);
    step(ir_of(7, 2, 0, 7), 16'h0, 0, 0, 0, 0, 0, 0);

    // Randomised traffic with occasional resets and biased bus values.
    for (int n = 0; n < 400; n++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: rbus = 16'h0000;
        1: rbus = 16'h8000;
        2: rbus = 16'h7FFF;
        default: rbus = 16'($urandom);
      endcase
      step(16'($urandom), rbus, 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0), 1'($urandom), ($urandom_range(0, 49) == 0));
    end
    step(ir_of(0, 0, 0, 0), 16'h0, 0, 0, 0, 0, 0, 0);
    drv_done = 1'b1;
  end

  initial begin
    wait (drv_done);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge Clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/reg_file_cc.md
# reg_file_cc

Register file and condition-code stage that sits directly upstream of the ALU in the SLC-3 datapath. It holds the eight 16-bit general registers R0–R7 and decodes the SR1, SR2 and DR fields from the instruction register. It drives the ALU A operand (SR1) and B operand (SR2 or sign-extended imm5). It latches results from the data bus, and maintains the NZP condition codes and the branch-enable flag (BEN).

## Interface
Parameters:
- None. The 16-bit datapath, 8 registers and IR field positions are fixed by the ISA.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- IR  in  16  current instruction register contents.
- Bus  in  16  datapath bus; write data for registers and the source for NZP.
- LD_REG  in  1  write Bus into the register selected by DR on the next edge.
- LD_CC  in  1  update NZP from Bus on the next edge.
- LD_BEN  in  1  update BEN on the next edge.
- DRMUX  in  1  DR select: 0 = IR[11:9], 1 = R7 (3'b111).
- SR1MUX  in  1  SR1 select: 0 = IR[11:9], 1 = IR[8:6].
- SR1_OUT  out  16  contents of the SR1 register; drives ALU A.
- ALU_B  out  16  drives ALU B. Equals sext(IR[4:0]) when IR[5]=1; otherwise the contents of register IR[2:0].
- NZP  out  3  condition codes {N,Z,P}.
- BEN  out  1  registered branch enable.

## Operation
- Storage: R0–R7, 16 bits each, flops with asynchronous reset to 16'h0000.
- Read paths are purely combinational from IR, SR1MUX and register state. SR1_OUT and ALU_B are valid in the same cycle IR/SR1MUX change.
- Sign extension: ALU_B = {{11{IR[4]}}, IR[4:0]}.
  - Example: IR[4:0]=5'b10000 gives 16'hFFF0.
  - Example: 5'b01111 gives 16'h000F.
- Register write: on a rising Clk edge with LD_REG=1, R[DR] <= Bus. No other register changes.
- NZP update on a rising edge with LD_CC=1:
  - N=1 when Bus[15]=1.
  - Else Z=1 when Bus==16'h0000.
  - Else P=1.
  - Exactly one bit is set after any update.
- BEN update on a rising edge with LD_BEN=1: BEN <= |(IR[11:9] & NZP). This uses the NZP value held before that edge.
- Simultaneous events:
  - LD_CC and LD_BEN in the same cycle: BEN is computed from the old NZP; NZP takes the new value.
  - LD_REG and a read of the same register in the same cycle: the read returns the old value until the edge, and the new value after it. There is no write-through bypass.
  - LD_REG with DRMUX=1 writes R7 regardless of IR[11:9].
- Reset:
  - R0–R7 = 16'h0000, NZP = 3'b000, BEN = 0.
  - Reset asserted mid-operation overrides any LD_* in the same cycle.
  - State stays cleared while Reset is held.
  - Outputs follow immediately (asynchronously): SR1_OUT = 16'h0000, and ALU_B = 16'h0000 unless IR[5]=1.

## Timing
- Read latency: 0 cycles (combinational from IR and register state).
- Write, NZP and BEN latency: 1 cycle. The value is visible on outputs just after the rising edge where the load is sampled high.
- Load enables are level-sampled at each edge; no handshake. Holding LD_REG high for N cycles performs N writes.
- Reset release is synchronous-safe: the first edge after Reset deasserts may perform a load.
- The critical path Bus -> NZP compare -> flop must fit in one cycle alongside the ALU/bus path.

## Test plan
- Reset, then read all eight registers via SR1MUX/IR sweeps -> every SR1_OUT = 16'h0000; NZP = 000; BEN = 0.
- Write R3 with Bus=16'h1234, DRMUX=0, IR[11:9]=3 and LD_REG=1 for one edge. Then set IR[8:6]=3, SR1MUX=1 -> SR1_OUT=16'h1234 and the other registers are still 0. Set IR[5]=0, IR[2:0]=3 -> ALU_B=16'h1234.
- IR[5]=1 with IR[4:0]=5'b10001 -> ALU_B=16'hFFF1. IR[4:0]=5'b00111 -> ALU_B=16'h0007, independent of register contents.
- LD_CC with Bus=16'h8000, then 16'h0000, then 16'h0001 -> NZP = 100, 010, 001 on successive cycles.
- NZP=010 with IR[11:9]=3'b010: LD_BEN -> BEN=1. Then assert LD_CC (Bus=16'h0005) and LD_BEN together -> BEN=1 and NZP=001. On the next LD_BEN -> BEN=0.
- DRMUX=1, LD_REG, Bus=16'hBEEF -> R7=16'hBEEF and R[IR[11:9]] unchanged. Assert Reset asynchronously mid-cycle -> R7 reads 16'h0000 before the next edge.
